// File: rtl/common_pkg.sv
// Shared data-bus types used by cores and bus responders across the codebase.
package common_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_responder_pkg.sv
// State encoding and latency-counter sizing for the data-bus responder.
package dbus_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dbus_resp_state_t;

  // Wide enough for LATENCY-2 with LATENCY up to 15.
  localparam int LAT_CNT_W = 4;
  typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

  function automatic lat_cnt_t lat_init(input int latency);
    return (latency >= 2) ? lat_cnt_t'(latency - 2) : '0;
  endfunction

endpackage

// File: rtl/dbus_resp_mem.sv
// Byte-strobed 64-bit word store: synchronous per-byte write, combinational read.
module dbus_resp_mem #(
  parameter int DEPTH_WORDS = 512,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       strobe_i,
  input  logic [63:0]      wdata_i,
  output logic [63:0]      rdata_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      // One array per byte lane keeps each write enable independent.
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (we_i && strobe_i[gi]) begin
          lane_mem[idx_i] <= wdata_i[8*gi +: 8];
        end
      end

      assign rdata_o[8*gi +: 8] = lane_mem[idx_i];
    end
  endgenerate

endmodule

// File: rtl/dbus_responder.sv
// Fixed-latency data-bus responder backed by a byte-strobed word store.
// Optional build macro DBUS_RESP_ALIGN_CHECK_EN rejects misaligned accesses with err.
module dbus_responder
  import common_pkg::*;
  import dbus_responder_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int       IDX_W    = $clog2(DEPTH_WORDS);
  localparam lat_cnt_t LAT_INIT = lat_init(LATENCY);

  dbus_resp_state_t state_q;
  lat_cnt_t         cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       strobe_q;
  logic [63:0]      wdata_q;
  logic [63:0]      rdata;
  logic             data_ok;
  logic             reject;
  logic             mem_we;

`ifdef DBUS_RESP_ALIGN_CHECK_EN
  logic rejected_d;
  logic rejected_q;

  assign rejected_d = (dreq.addr & ((64'd1 << dreq.size) - 64'd1)) != 64'd0;
  assign reject     = rejected_q;
`else
  logic unused_req_bits;

  assign unused_req_bits = ^{dreq.addr[63:3+IDX_W], dreq.addr[2:0], dreq.size};
  assign reject          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dreq.valid) begin
            idx_q    <= dreq.addr[3 +: IDX_W];
            strobe_q <= dreq.strobe;
            wdata_q  <= dreq.data;
`ifdef DBUS_RESP_ALIGN_CHECK_EN
            rejected_q <= rejected_d;
`endif
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset gating aborts an in-flight response before it can write or complete.
  assign data_ok       = (state_q == RESP) && !reset;
  assign mem_we        = data_ok && !reject;
  assign dresp.addr_ok = (state_q == IDLE) && dreq.valid && !reset;
  assign dresp.data_ok = data_ok;
  assign dresp.data    = mem_we ? rdata : 64'd0;
  assign err           = data_ok && reject;

  // Read data is sampled in RESP, before the write lands at the closing edge.
  dbus_resp_mem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .idx_i   (idx_q),
    .strobe_i(strobe_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder: vector table plus scoreboard of expected responses.
module tb_dbus_responder;
  import common_pkg::*;

  localparam int LATENCY     = 2;
  localparam int DEPTH_WORDS = 512;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       err;

  dbus_responder #(
    .LATENCY    (LATENCY),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .dreq (dreq),
    .dresp(dresp),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] data;
    logic        err;
    logic        chk;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_err;
    logic        chk;
  } vec_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_hist[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dok_cnt = 0;
  bit   mon_en = 1'b0;
  vec_t tbl[11];

  always @(posedge clk) cyc <= cyc + 1;

  exp_t m_e;
  int   m_a;
  always @(negedge clk) begin
    if (mon_en) begin
      if (dresp.addr_ok) begin
        acc_q.push_back(cyc);
        acc_hist.push_back(cyc);
      end
      if (dresp.data_ok) begin
        dok_cnt++;
        checks++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_data_ok: got data_ok=1 at cycle %0d, required none", cyc);
        end else begin
          m_e = exp_q.pop_front();
          m_a = acc_q.pop_front();
          if (cyc - m_a != LATENCY) begin
            errors++;
            $display("FAIL txn%0d_latency: got %0d cycles, required %0d", m_e.id, cyc - m_a, LATENCY);
          end
          checks++;
          if (err !== m_e.err) begin
            errors++;
            $display("FAIL txn%0d_err: got %b, required %b", m_e.id, err, m_e.err);
          end
          if (m_e.chk) begin
            checks++;
            if (dresp.data !== m_e.data) begin
              errors++;
              $display("FAIL txn%0d_data: got %h, required %h", m_e.id, dresp.data, m_e.data);
            end
          end
          $display("txn%0d done at cycle %0d data=%h err=%b", m_e.id, cyc, dresp.data, err);
        end
      end else begin
        checks++;
        if (dresp.data !== 64'd0 || err !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: got data=%h err=%b at cycle %0d, required 0/0", dresp.data, err, cyc);
        end
      end
    end
  end

  task automatic wait_accept(input int id);
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (dresp.addr_ok) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL txn%0d_accept: got no addr_ok in 20 cycles, required addr_ok", id);
    end
  endtask

  task automatic wait_drain(input int id);
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL txn%0d_drain: got %0d pending responses, required 0", id, exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic do_txn(input int id, input logic [63:0] addr, input msize_t size,
                        input logic [7:0] strobe, input logic [63:0] wdata,
                        input logic [63:0] exp_data, input logic exp_err, input logic chk);
    exp_t e;
    e = '{id: id, data: exp_data, err: exp_err, chk: chk};
    @(posedge clk);
    #1;
    dreq = '{valid: 1'b1, addr: addr, size: size, strobe: strobe, data: wdata};
    exp_q.push_back(e);
    wait_accept(id);
    @(posedge clk);
    #1;
    // Scramble the request after acceptance; the responder must ignore it.
    dreq.valid  = 1'b0;
    dreq.addr   = {$urandom, $urandom};
    dreq.size   = msize_t'($urandom_range(0, 3));
    dreq.strobe = 8'hFF;
    dreq.data   = {$urandom, $urandom};
    wait_drain(id);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion in time, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int d0;
    dreq = '0;
    tbl[0]  = '{64'h0000_0000_8000_0000, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b0, 1'b1};
    tbl[1]  = '{64'h0000_0000_8000_0008, MSIZE8, 8'hFF, 64'h1122334455667788, 64'h0, 1'b0, 1'b1};
    tbl[2]  = '{64'h0000_0000_8000_0008, MSIZE8, 8'h00, 64'h0, 64'h1122334455667788, 1'b0, 1'b1};
    tbl[3]  = '{64'h0000_0000_8000_0008, MSIZE1, 8'h01, 64'h00000000000000AA, 64'h1122334455667788, 1'b0, 1'b1};
    tbl[4]  = '{64'h0000_0000_8000_0008, MSIZE8, 8'h00, 64'h0, 64'h11223344556677AA, 1'b0, 1'b1};
    tbl[5]  = '{64'h0000_0000_8000_1008, MSIZE8, 8'h00, 64'h0, 64'h11223344556677AA, 1'b0, 1'b1};
    tbl[6]  = '{64'h0000_0000_8000_1008, MSIZE8, 8'hF0, 64'hDEADBEEF00000000, 64'h11223344556677AA, 1'b0, 1'b1};
    tbl[7]  = '{64'h0000_0000_8000_0008, MSIZE8, 8'h00, 64'h0, 64'hDEADBEEF556677AA, 1'b0, 1'b1};
    tbl[8]  = '{64'hFFFF_0000_8000_0000, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b0, 1'b1};
    tbl[9]  = '{64'h0000_0000_8000_0000, MSIZE8, 8'h3C, 64'h0102030405060708, 64'h0, 1'b0, 1'b1};
    tbl[10] = '{64'h0000_0000_8000_0000, MSIZE8, 8'h00, 64'h0, 64'h0000030405060000, 1'b0, 1'b1};

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dresp.addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok: got %b, required 0", dresp.addr_ok); end
    checks++;
    if (dresp.data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got %b, required 0", dresp.data_ok); end
    checks++;
    if (dresp.data !== 64'd0) begin errors++; $display("FAIL reset_data: got %h, required 0", dresp.data); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
    $display("reset state checked at cycle %0d", cyc);
    mon_en = 1'b1;

    // Give the words under test known contents, then reset again (store must survive).
    do_txn(100, 64'h8000_0000, MSIZE8, 8'hFF, 64'h0, 64'h0, 1'b0, 1'b0);
    do_txn(101, 64'h8000_0008, MSIZE8, 8'hFF, 64'h0, 64'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_txn(i, tbl[i].addr, tbl[i].size, tbl[i].strobe, tbl[i].wdata,
             tbl[i].exp_data, tbl[i].exp_err, tbl[i].chk);
    end

    // Back-to-back: request held valid, address changed while busy.
    n0 = acc_hist.size();
    exp_q.push_back('{id: 200, data: 64'hDEADBEEF556677AA, err: 1'b0, chk: 1'b1});
    exp_q.push_back('{id: 201, data: 64'h0000030405060000, err: 1'b0, chk: 1'b1});
    @(posedge clk);
    #1;
    dreq = '{valid: 1'b1, addr: 64'h8000_0008, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    wait_accept(200);
    @(posedge clk);
    #1;
    dreq.addr = 64'h8000_0000;
    for (int k = 0; k < 20 && acc_hist.size() < n0 + 2; k++) @(negedge clk);
    @(posedge clk);
    #1;
    dreq.valid = 1'b0;
    wait_drain(201);
    checks++;
    if (acc_hist.size() < n0 + 2) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d accepts, required 2", acc_hist.size() - n0);
    end else if (acc_hist[n0+1] - acc_hist[n0] != LATENCY + 1) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles, required %0d", acc_hist[n0+1] - acc_hist[n0], LATENCY + 1);
    end
    $display("b2b pair accepted");

    // Reset while a write waits: no data_ok, old contents kept.
    d0 = dok_cnt;
    @(posedge clk);
    #1;
    dreq = '{valid: 1'b1, addr: 64'h8000_0008, size: MSIZE8, strobe: 8'hFF, data: 64'hFFFF_FFFF_FFFF_FFFF};
    wait_accept(300);
    @(posedge clk);
    #1;
    dreq.valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    acc_q.delete();
    repeat (4) @(negedge clk);
    checks++;
    if (dok_cnt != d0) begin
      errors++;
      $display("FAIL abort_data_ok: got %0d data_ok pulses, required 0", dok_cnt - d0);
    end
    $display("mid-transaction reset applied");
    do_txn(301, 64'h8000_0008, MSIZE8, 8'h00, 64'h0, 64'hDEADBEEF556677AA, 1'b0, 1'b1);

`ifdef DBUS_RESP_ALIGN_CHECK_EN
    do_txn(400, 64'h8000_0002, MSIZE4, 8'h3C, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1);
    do_txn(401, 64'h8000_0000, MSIZE8, 8'h00, 64'h0, 64'h0000030405060000, 1'b0, 1'b1);
`endif

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
